decode_regread_sb: RTL and testbench

- Parametrised decode-stage register-read block: multi-entry register file, write-before-read bypass and a per-register pending-write scoreboard.
- Generates RAW stalls and presents operands to execute through a registered valid/ready output slot.
- Sits between the IF/ID latch and execute; the writeback stage drives its write port.
- Replaces the fixed 8x16 regfile-plus-mux path with a hazard-aware, handshaked stage.

---
 rtl/decode_regread_sb.sv | 177 +++++++++++++++++
 tb/tb_decode_regread_sb.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/decode_regread_sb.sv
// decode_regread_sb
// Decode-stage register read with a hazard-aware, handshaked output slot.
// The register file is written by writeback, and a writeback is bypassed into
// a same-cycle read. A per-register pending-write counter detects RAW hazards.
// A full pending counter also blocks issue as a structural hazard.
// Operands are then captured into a registered valid/ready slot for execute.
//
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   in_valid / in_ready        decoded instruction handshake (in_ready is combinational)
//   rd1_sel/rd1_used,
//   rd2_sel/rd2_used           source selects and whether each source is really read
//   dst_sel / dst_wr           destination register and write flag
//   out_valid / out_ready      operand slot handshake toward execute
//   out_rd1_data, out_rd2_data captured operands
//   out_dst_sel, out_dst_wr    destination carried forward
//   wb_en / wb_sel / wb_data   writeback port
//   flush                      full pipeline squash
//   stall_cnt                  saturating count of stalled cycles
//   err                        one-cycle pulse on an illegal writeback
module decode_regread_sb #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rd1_sel,
  input  logic [REG_AW-1:0] rd2_sel,
  input  logic              rd1_used,
  input  logic              rd2_used,
  input  logic [REG_AW-1:0] dst_sel,
  input  logic              dst_wr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rd1_data,
  output logic [DATA_W-1:0] out_rd2_data,
  output logic [REG_AW-1:0] out_dst_sel,
  output logic              out_dst_wr,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic [15:0]       stall_cnt,
  output logic              err
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regFile_q [NREG];
  logic [CNT_W-1:0]  pend_q    [NREG];
  logic [CNT_W-1:0]  pend_d    [NREG];

  logic              outValid_q;
  logic [DATA_W-1:0] outRd1_q, outRd2_q;
  logic [REG_AW-1:0] outDstSel_q;
  logic              outDstWr_q;
  logic [15:0]       stallCnt_q;
  logic              err_q;

  logic [DATA_W-1:0] rd1Reg, rd2Reg, rd1Data, rd2Data;
  logic [CNT_W-1:0]  rd1Pend, rd2Pend, dstPend, wbPend;
  logic              wbSelOk, rd1Hit, rd2Hit, dstHit;
  logic              haz1, haz2, structHaz, ready, issue, errNext;

  // Select-driven lookups are written as decode loops, so any select beyond
  // NREG reads as zero and never indexes outside the arrays.
  always_comb begin
    rd1Reg  = '0;
    rd2Reg  = '0;
    rd1Pend = '0;
    rd2Pend = '0;
    dstPend = '0;
    wbPend  = '0;
    wbSelOk = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (rd1_sel == REG_AW'(i)) begin
        rd1Reg  = regFile_q[i];
        rd1Pend = pend_q[i];
      end
      if (rd2_sel == REG_AW'(i)) begin
        rd2Reg  = regFile_q[i];
        rd2Pend = pend_q[i];
      end
      if (dst_sel == REG_AW'(i)) dstPend = pend_q[i];
      if (wb_sel == REG_AW'(i)) begin
        wbPend  = pend_q[i];
        wbSelOk = 1'b1;
      end
    end
  end

  // A writeback that retires the last outstanding write to a source clears the
  // hazard in the same cycle, because the bypass supplies the fresh value.
  always_comb begin
    rd1Hit    = wb_en && wbSelOk && (wb_sel == rd1_sel);
    rd2Hit    = wb_en && wbSelOk && (wb_sel == rd2_sel);
    dstHit    = wb_en && wbSelOk && (wb_sel == dst_sel);
    rd1Data   = rd1Hit ? wb_data : rd1Reg;
    rd2Data   = rd2Hit ? wb_data : rd2Reg;
    haz1      = rd1_used && (rd1Pend != '0) && !(rd1Hit && (rd1Pend == PEND_ONE));
    haz2      = rd2_used && (rd2Pend != '0) && !(rd2Hit && (rd2Pend == PEND_ONE));
    structHaz = dst_wr && (dstPend == PEND_MAX) && !dstHit;
    ready     = !flush && !haz1 && !haz2 && !structHaz && (!outValid_q || out_ready);
    issue     = in_valid && ready;
    errNext   = wb_en && (!wbSelOk || (wbPend == '0));
  end

  // Scoreboard next state. A decrement on an idle counter is dropped, so a
  // stray writeback cannot wrap it. The structural hazard keeps increments
  // from overflowing.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      pend_d[i] = pend_q[i];
      if (flush) begin
        pend_d[i] = '0;
      end else begin
        if ((issue && dst_wr && (dst_sel == REG_AW'(i))) &&
            !(wb_en && (wb_sel == REG_AW'(i)) && (pend_q[i] != '0)))
          pend_d[i] = pend_q[i] + PEND_ONE;
        else if (!(issue && dst_wr && (dst_sel == REG_AW'(i))) &&
                 (wb_en && (wb_sel == REG_AW'(i)) && (pend_q[i] != '0)))
          pend_d[i] = pend_q[i] - PEND_ONE;
      end
    end
  end

  // Register file, scoreboard, operand slot and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regFile_q[i] <= '0;
        pend_q[i]    <= '0;
      end
      outValid_q  <= 1'b0;
      outRd1_q    <= '0;
      outRd2_q    <= '0;
      outDstSel_q <= '0;
      outDstWr_q  <= 1'b0;
      stallCnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wb_en && (wb_sel == REG_AW'(i))) regFile_q[i] <= wb_data;
        pend_q[i] <= pend_d[i];
      end
      if (flush) begin
        outValid_q <= 1'b0;
      end else if (issue) begin
        outValid_q  <= 1'b1;
        outRd1_q    <= rd1Data;
        outRd2_q    <= rd2Data;
        outDstSel_q <= dst_sel;
        outDstWr_q  <= dst_wr;
      end else if (outValid_q && out_ready) begin
        outValid_q <= 1'b0;
      end
      if (in_valid && !ready && !flush && (stallCnt_q != 16'hFFFF))
        stallCnt_q <= stallCnt_q + 16'd1;
      err_q <= errNext;
    end
  end

  assign in_ready     = ready;
  assign out_valid    = outValid_q;
  assign out_rd1_data = outRd1_q;
  assign out_rd2_data = outRd2_q;
  assign out_dst_sel  = outDstSel_q;
  assign out_dst_wr   = outDstWr_q;
  assign stall_cnt    = stallCnt_q;
  assign err          = err_q;

endmodule

// File: tb/tb_decode_regread_sb.sv
// tb_decode_regread_sb
// Self-checking bench for decode_regread_sb. It applies a table of one-cycle
// vectors with hand-computed expectations. Separate sequences then cover
// stall counter saturation and a reset asserted mid-operation.
module tb_decode_regread_sb;

  typedef struct {
    int inValid, rd1Sel, rd1Used, rd2Sel, rd2Used, dstSel, dstWr, outReady;
    int wbEn, wbSel, wbData, flush;
    int expInReady, expOutValid, chkData, expRd1, expRd2, expDstSel, expDstWr;
    int expErr, expStall;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        inValid, inReady;
  logic [2:0]  rd1Sel, rd2Sel, dstSel, wbSel, outDstSel;
  logic        rd1Used, rd2Used, dstWr;
  logic        outValid, outReady, outDstWr;
  logic [15:0] outRd1Data, outRd2Data, wbData, stallCnt;
  logic        wbEn, flush, err;

  int nCompared;
  int nMismatched;
  vec_t vecs[$];

  decode_regread_sb #(.DATA_W(16), .NREG(8), .REG_AW(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady),
    .rd1_sel(rd1Sel), .rd2_sel(rd2Sel),
    .rd1_used(rd1Used), .rd2_used(rd2Used),
    .dst_sel(dstSel), .dst_wr(dstWr),
    .out_valid(outValid), .out_ready(outReady),
    .out_rd1_data(outRd1Data), .out_rd2_data(outRd2Data),
    .out_dst_sel(outDstSel), .out_dst_wr(outDstWr),
    .wb_en(wbEn), .wb_sel(wbSel), .wb_data(wbData),
    .flush(flush), .stall_cnt(stallCnt), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input vec_t v);
    inValid  = v.inValid[0];
    rd1Sel   = v.rd1Sel[2:0];
    rd1Used  = v.rd1Used[0];
    rd2Sel   = v.rd2Sel[2:0];
    rd2Used  = v.rd2Used[0];
    dstSel   = v.dstSel[2:0];
    dstWr    = v.dstWr[0];
    outReady = v.outReady[0];
    wbEn     = v.wbEn[0];
    wbSel    = v.wbSel[2:0];
    wbData   = v.wbData[15:0];
    flush    = v.flush[0];
  endtask

  task automatic checkOutput(input string name, input int step, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s step %0d: got %0h, expected %0h", name, step, actual, expected);
    end
  endtask

  function automatic vec_t idleVec();
    return vec_t'{0,0,0,0,0,0,0,1, 0,0,0,0, 0,0,0,0,0,0,0, 0,0};
  endfunction

  initial begin
    vec_t v;
    nCompared   = 0;
    nMismatched = 0;

    //            iv r1 u1 r2 u2 ds dw or  we ws wdata    fl   ir ov cd rd1      rd2      eds edw err stall
    vecs.push_back(vec_t'{0, 0,0, 0,0, 0,0, 1,  1,3,'h1234, 0,   1, 0, 0, 0,       0,       0,  0,  1,  0});
    vecs.push_back(vec_t'{1, 3,1, 0,1, 0,0, 1,  0,0,0,      0,   1, 1, 1, 'h1234,  0,       0,  0,  0,  0});
    vecs.push_back(vec_t'{1, 0,1, 3,0, 2,1, 1,  0,0,0,      0,   1, 1, 1, 0,       'h1234,  2,  1,  0,  0});
    vecs.push_back(vec_t'{1, 2,1, 0,0, 0,0, 1,  0,0,0,      0,   0, 0, 0, 0,       0,       0,  0,  0,  1});
    vecs.push_back(vec_t'{1, 2,1, 0,0, 0,0, 1,  0,0,0,      0,   0, 0, 0, 0,       0,       0,  0,  0,  2});
    vecs.push_back(vec_t'{1, 2,1, 0,0, 0,0, 1,  1,2,'hBEEF, 0,   1, 1, 1, 'hBEEF,  0,       0,  0,  0,  2});
    for (int k = 0; k < 5; k++)
      vecs.push_back(vec_t'{1, 3,1, 2,1, 7,0, 0, 0,0,0,     0,   0, 1, 1, 'hBEEF,  0,       0,  0,  0,  3 + k});
    vecs.push_back(vec_t'{1, 3,1, 2,1, 7,0, 1,  0,0,0,      0,   1, 1, 1, 'h1234,  'hBEEF,  7,  0,  0,  7});
    for (int k = 0; k < 3; k++)
      vecs.push_back(vec_t'{1, 0,0, 0,0, 5,1, 1, 0,0,0,     0,   1, 1, 1, 0,       0,       5,  1,  0,  7});
    vecs.push_back(vec_t'{1, 0,0, 0,0, 5,1, 1,  0,0,0,      0,   0, 0, 0, 0,       0,       0,  0,  0,  8});
    vecs.push_back(vec_t'{1, 0,0, 0,0, 5,1, 1,  1,5,'h5555, 0,   1, 1, 1, 0,       0,       5,  1,  0,  8});
    vecs.push_back(vec_t'{0, 0,0, 0,0, 0,0, 1,  1,4,'h4444, 0,   1, 0, 0, 0,       0,       0,  0,  1,  8});
    vecs.push_back(vec_t'{0, 0,0, 0,0, 0,0, 1,  0,0,0,      0,   1, 0, 0, 0,       0,       0,  0,  0,  8});
    vecs.push_back(vec_t'{1, 0,0, 0,0, 1,1, 1,  0,0,0,      0,   1, 1, 1, 0,       0,       1,  1,  0,  8});
    vecs.push_back(vec_t'{1, 0,0, 0,0, 1,1, 1,  0,0,0,      0,   1, 1, 1, 0,       0,       1,  1,  0,  8});
    vecs.push_back(vec_t'{1, 0,0, 0,0, 1,1, 0,  1,6,'h00FF, 1,   0, 0, 0, 0,       0,       0,  0,  1,  8});
    vecs.push_back(vec_t'{1, 1,1, 6,1, 0,0, 1,  0,0,0,      0,   1, 1, 1, 0,       'h00FF,  0,  0,  0,  8});
    vecs.push_back(vec_t'{1, 5,1, 4,1, 0,0, 1,  0,0,0,      0,   1, 1, 1, 'h5555,  'h4444,  0,  0,  0,  8});

    // Reset state
    rst = 1'b0;
    applyStimulus(idleVec());
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetOutValid", -1, int'(outValid), 0);
    checkOutput("resetStall", -1, int'(stallCnt), 0);
    checkOutput("resetErr", -1, int'(err), 0);
    checkOutput("resetRd1", -1, int'(outRd1Data), 0);
    rst = 1'b1;

    // Table-driven vectors, one clock each
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(v);
      #1;
      checkOutput("inReady", i, int'(inReady), v.expInReady);
      @(posedge clk);
      #1;
      checkOutput("outValid", i, int'(outValid), v.expOutValid);
      checkOutput("err", i, int'(err), v.expErr);
      checkOutput("stallCnt", i, int'(stallCnt), v.expStall);
      if (v.chkData != 0) begin
        checkOutput("outRd1", i, int'(outRd1Data), v.expRd1);
        checkOutput("outRd2", i, int'(outRd2Data), v.expRd2);
        checkOutput("outDstSel", i, int'(outDstSel), v.expDstSel);
        checkOutput("outDstWr", i, int'(outDstWr), v.expDstWr);
      end
    end

    // Stall counter saturation: make r7 pending, then hold a dependent read
    v = idleVec();
    v.inValid = 1; v.dstSel = 7; v.dstWr = 1;
    applyStimulus(v);
    #1;
    checkOutput("satIssue", 100, int'(inReady), 1);
    @(posedge clk);
    #1;
    v = idleVec();
    v.inValid = 1; v.rd1Sel = 7; v.rd1Used = 1;
    applyStimulus(v);
    repeat (65540) @(posedge clk);
    #1;
    checkOutput("satInReady", 101, int'(inReady), 0);
    checkOutput("satStall", 101, int'(stallCnt), 'hFFFF);

    // Reset asserted mid-operation with a writeback pending on the same edge
    v = idleVec();
    v.wbEn = 1; v.wbSel = 3; v.wbData = 'hAAAA;
    applyStimulus(v);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midRstOutValid", 102, int'(outValid), 0);
    checkOutput("midRstStall", 102, int'(stallCnt), 0);
    checkOutput("midRstErr", 102, int'(err), 0);
    @(posedge clk);
    #1;
    applyStimulus(idleVec());
    rst = 1'b1;
    v = idleVec();
    v.inValid = 1; v.rd1Sel = 3; v.rd1Used = 1; v.rd2Sel = 7; v.rd2Used = 1;
    applyStimulus(v);
    #1;
    checkOutput("postRstInReady", 103, int'(inReady), 1);
    @(posedge clk);
    #1;
    checkOutput("postRstOutValid", 103, int'(outValid), 1);
    checkOutput("postRstRd1", 103, int'(outRd1Data), 0);
    checkOutput("postRstRd2", 103, int'(outRd2Data), 0);
    applyStimulus(idleVec());
    @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
